// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register bridge: response codes, FSM states
// and the command address legality check.
package uart_reg_pkg;

    localparam logic [7:0] RSP_ACK    = 8'hA5;
    localparam logic [7:0] RSP_ERR    = 8'hEE;
    localparam int         CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        COMMIT,
        RESP_LOAD,
        RESP_SEND,
        RESP_WAIT
    } bridge_state_t;

    // Unused command bits between the address field and the write flag must be zero.
    function automatic logic addr_legal(input logic [7:0] cmd, input int addr_w, input int num_regs);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i >= addr_w && cmd[i]) ok = 1'b0;
        end
        if ((int'(cmd[6:0]) & ((1 << addr_w) - 1)) >= num_regs) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/uart_reg_bank.sv
// Register storage for the UART bridge: NUM_REGS words with one write port,
// a read mux and a flattened view of every word.
module uart_reg_bank
    import uart_reg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 12
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [ADDR_W-1:0]            raddr,
    output logic [DATA_W-1:0]            rdata,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!nRst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) mem[i] <= wdata;
            end
        end
    end

    // Addresses beyond NUM_REGS read as zero; the bridge never exposes them anyway.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == ADDR_W'(i)) rdata = mem[i];
        end
    end

    always_comb begin
        regs_q = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_q[i*DATA_W +: DATA_W] = mem[i];
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// UART byte-command bridge to a register bank. Optional write-data timeout is
// enabled with the UART_REG_BRIDGE_TIMEOUT_EN macro.
//
// state     | meaning
// IDLE      | waiting for a command byte
// WR_DATA   | collecting write data bytes, MSB byte first
// COMMIT    | one cycle: write the word (if legal) and queue ACK/ERR
// RESP_LOAD | waiting for tx idle, then launch the next response byte
// RESP_SEND | one cycle after launch, tx_busy not yet trusted
// RESP_WAIT | waiting for the byte to finish, then next byte or IDLE
module uart_reg_bridge
    import uart_reg_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 12
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1_000_000
`endif
) (
    input  logic                                clk,
    input  logic                                nRst,
    input  logic                                rx_valid,
    input  logic [7:0]                          rx_data,
    output logic                                tx_start,
    output logic [7:0]                          tx_data,
    input  logic                                tx_busy,
    output logic [NUM_REGS*8*DATA_BYTES-1:0]    regs_q,
    output logic                                wr_strobe,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic                                drop_err
);

    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int CNT_W  = $clog2(DATA_BYTES + 1);

    bridge_state_t     state, state_nxt;
    logic [7:0]        cmd;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_data;
    logic              rx_legal, cmd_legal;
    logic              bank_we, tx_fire, byte_done, drop_hit, timeout;

    assign rx_legal  = addr_legal(rx_data, ADDR_W, NUM_REGS);
    assign cmd_legal = addr_legal(cmd, ADDR_W, NUM_REGS);

    uart_reg_bank #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk    (clk),
        .nRst   (nRst),
        .we     (bank_we),
        .waddr  (cmd[ADDR_W-1:0]),
        .wdata  (sr),
        .raddr  (rx_data[ADDR_W-1:0]),
        .rdata  (rd_data),
        .regs_q (regs_q)
    );

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || rx_valid) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
        end else if (state == WR_DATA && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    assign timeout = (state == WR_DATA) && !rx_valid && (tmo_cnt == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rx_valid) state_nxt = rx_data[CMD_WR_BIT] ? WR_DATA : RESP_LOAD;
            WR_DATA: begin
                if (timeout)
                    state_nxt = IDLE;
                else if (rx_valid && cnt == CNT_W'(DATA_BYTES - 1))
                    state_nxt = COMMIT;
            end
            COMMIT:    state_nxt = RESP_LOAD;
            RESP_LOAD: if (!tx_busy) state_nxt = RESP_SEND;
            RESP_SEND: state_nxt = RESP_WAIT;
            RESP_WAIT: if (!tx_busy) state_nxt = (cnt == CNT_W'(1)) ? IDLE : RESP_LOAD;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bank_we   = (state == COMMIT) && cmd_legal;
        tx_fire   = (state == RESP_LOAD) && !tx_busy;
        byte_done = (state == RESP_WAIT) && !tx_busy;
        drop_hit  = rx_valid && (state inside {COMMIT, RESP_LOAD, RESP_SEND, RESP_WAIT});
    end

    // sr doubles as the write assembly register and the response shift register.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            cmd       <= '0;
            sr        <= '0;
            cnt       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            drop_err  <= 1'b0;
        end else begin
            tx_start  <= tx_fire;
            wr_strobe <= bank_we;
            if (tx_fire)  tx_data  <= sr[DATA_W-1 -: 8];
            if (bank_we)  wr_addr  <= cmd[ADDR_W-1:0];
            if (drop_hit) drop_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cmd <= rx_data;
                        cnt <= '0;
                        if (!rx_data[CMD_WR_BIT]) begin
                            if (rx_legal) begin
                                sr  <= rd_data;
                                cnt <= CNT_W'(DATA_BYTES);
                            end else begin
                                sr  <= DATA_W'(RSP_ERR) << (DATA_W - 8);
                                cnt <= CNT_W'(1);
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        sr  <= (sr << 8) | DATA_W'(rx_data);
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    sr  <= DATA_W'(cmd_legal ? RSP_ACK : RSP_ERR) << (DATA_W - 8);
                    cnt <= CNT_W'(1);
                end
                RESP_WAIT: begin
                    if (byte_done) begin
                        sr  <= sr << 8;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed self-checking bench for uart_reg_bridge; the timeout scenario runs
// only when UART_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_reg_bridge;

    localparam int DB = 2;
    localparam int AW = 4;
    localparam int NR = 12;
    localparam int DW = 8 * DB;

    logic              clk = 1'b0;
    logic              nRst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [NR*DW-1:0]  regs_q;
    logic              wr_strobe;
    logic [AW-1:0]     wr_addr;
    logic              drop_err;

    int                errors = 0;
    int                checks = 0;
    int                busy_len = 2;
    int                busy_left = 0;
    int                strobe_cnt = 0;
    logic [AW-1:0]     strobe_addr = '0;
    logic [7:0]        last_tx = '0;
    logic [7:0]        txq[$];
    logic [NR*DW-1:0]  snap;
    int                s_cnt;

    uart_reg_bridge #(
        .DATA_BYTES (DB),
        .ADDR_W     (AW),
        .NUM_REGS   (NR)
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
        , .TIMEOUT_CYC (50)
`endif
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .regs_q    (regs_q),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] reg_at(input int n);
        return regs_q[n*DW +: DW];
    endfunction

    // Transmitter model: busy for busy_len cycles per started byte; also logs bytes and strobes.
    always @(posedge clk) begin
        #1;
        if (!nRst) begin
            last_tx   = tx_data;
            busy_left = 0;
            tx_busy   = 1'b0;
        end else begin
            if (tx_start) begin
                txq.push_back(tx_data);
                last_tx   = tx_data;
                busy_left = busy_len;
                tx_busy   = 1'b1;
            end else begin
                check("tx_data_hold", {24'h0, tx_data}, {24'h0, last_tx});
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) tx_busy = 1'b0;
                end
            end
            if (wr_strobe) begin
                strobe_cnt++;
                strobe_addr = wr_addr;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k;
        k = 0;
        while (txq.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (busy_len + 6) @(negedge clk);
        check(tag, txq.size(), n);
    endtask

    initial begin
        nRst     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_regs",      {31'h0, |regs_q}, 32'h0);
        check("rst_tx_start",  tx_start, 0);
        check("rst_tx_data",   tx_data, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr",   wr_addr, 0);
        check("rst_drop_err",  drop_err, 0);
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        // write 0x1234 to reg 3, then read it back
        send_byte(8'h83);
        send_byte(8'h12);
        send_byte(8'h34);
        check("wr_pre_commit_reg3", reg_at(3), 16'h0000);
        check("wr_pre_strobe", wr_strobe, 0);
        @(negedge clk);
        check("wr_reg3", reg_at(3), 16'h1234);
        check("wr_strobe_pulse", wr_strobe, 1);
        check("wr_addr", wr_addr, 3);
        @(negedge clk);
        check("wr_strobe_low", wr_strobe, 0);
        wait_tx(1, "wr_ack_count");
        check("wr_ack", txq[0], 8'hA5);
        check("wr_strobe_cnt", strobe_cnt, 1);
        check("wr_strobe_addr", strobe_addr, 3);
        txq.delete();
        send_byte(8'h03);
        wait_tx(2, "rd_count");
        check("rd_msb", txq[0], 8'h12);
        check("rd_lsb", txq[1], 8'h34);

        // illegal addresses
        snap = regs_q;
        txq.delete();
        send_byte(8'h8D);
        send_byte(8'hFF);
        send_byte(8'hFF);
        wait_tx(1, "ill_wr_count");
        check("ill_wr_err", txq[0], 8'hEE);
        check("ill_wr_nostrobe", strobe_cnt, 1);
        check("ill_wr_nowrite", {31'h0, regs_q === snap}, 1);
        txq.delete();
        send_byte(8'h0E);
        wait_tx(1, "ill_rd_count");
        check("ill_rd_err", txq[0], 8'hEE);
        txq.delete();
        send_byte(8'h13);
        wait_tx(1, "ill_hi_count");
        check("ill_hi_err", txq[0], 8'hEE);

        // byte arriving during a response is dropped and flagged
        busy_len = 10;
        txq.delete();
        send_byte(8'h00);
        for (int k = 0; k < 100 && !tx_busy; k++) @(negedge clk);
        send_byte(8'h55);
        check("drop_flag", drop_err, 1);
        wait_tx(2, "drop_rd_count");
        check("drop_rd_msb", txq[0], 8'h00);
        check("drop_rd_lsb", txq[1], 8'h00);
        txq.delete();
        send_byte(8'h03);
        wait_tx(2, "after_drop_count");
        check("after_drop_msb", txq[0], 8'h12);
        check("after_drop_lsb", txq[1], 8'h34);
        check("drop_sticky", drop_err, 1);

        // reset in the middle of a write
        busy_len = 2;
        txq.delete();
        s_cnt = strobe_cnt;
        send_byte(8'h81);
        send_byte(8'hAA);
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        check("mid_rst_regs", {31'h0, |regs_q}, 0);
        check("mid_rst_drop", drop_err, 0);
        repeat (10) @(negedge clk);
        check("mid_rst_no_tx", txq.size(), 0);
        check("mid_rst_no_strobe", strobe_cnt, s_cnt);
        send_byte(8'h81);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_tx(1, "post_rst_count");
        check("post_rst_ack", txq[0], 8'hA5);
        check("post_rst_reg1", reg_at(1), 16'h0102);

        // slow transmitter
        busy_len = 20;
        txq.delete();
        send_byte(8'h85);
        send_byte(8'hBE);
        send_byte(8'hEF);
        wait_tx(1, "slow_wr_count");
        check("slow_wr_ack", txq[0], 8'hA5);
        txq.delete();
        send_byte(8'h05);
        wait_tx(2, "slow_rd_count");
        check("slow_rd_msb", txq[0], 8'hBE);
        check("slow_rd_lsb", txq[1], 8'hEF);
        check("slow_reg5", reg_at(5), 16'hBEEF);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
        // stalled write is abandoned, so 0x02 becomes a read of untouched reg 2
        busy_len = 2;
        txq.delete();
        send_byte(8'h82);
        send_byte(8'h11);
        repeat (60) @(negedge clk);
        check("tmo_no_resp", txq.size(), 0);
        send_byte(8'h02);
        wait_tx(2, "tmo_rd_count");
        check("tmo_rd_msb", txq[0], 8'h00);
        check("tmo_rd_lsb", txq[1], 8'h00);
        check("tmo_reg2", reg_at(2), 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Byte-protocol bridge between the UART byte stream and an internal parametrised register bank. Parses read/write commands arriving as UART bytes, updates or reads NUM_REGS registers of DATA_W bits, and returns response bytes through the UART transmitter. Multi-byte data words, out-of-range address errors and a sticky drop flag are included.

Parameters:
DATA_BYTES, 2, bytes per register word; DATA_W = 8*DATA_BYTES
ADDR_W, 4, register address width, legal range 1..7
NUM_REGS, 12, implemented registers, legal range 1..2**ADDR_W; addresses >= NUM_REGS are illegal

Ports:
clk  in  1  system clock
nRst  in  1  synchronous active-low reset, sampled on rising clk
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_data  out  8  byte to transmit, held stable from tx_start until the next tx_start
tx_busy  in  1  UART transmitter busy; rises no later than the cycle after tx_start
regs_q  out  NUM_REGS*DATA_W  flattened register contents; reg n at [n*DATA_W +: DATA_W]
wr_strobe  out  1  one-cycle pulse when a register write commits
wr_addr  out  ADDR_W  address of the last committed write
drop_err  out  1  sticky: a byte arrived while a response was being sent

Behaviour:
- Reset (nRst=0 at a clk edge): all registers 0, tx_start=0, tx_data=0, wr_strobe=0, wr_addr=0, drop_err=0, FSM=IDLE, byte counter=0. Reset mid-command aborts it with no write and no response.
- Command byte: bit7=1 write, 0 read; bits[ADDR_W-1:0] address. Bits[6:ADDR_W] must be 0, else the address is illegal.
- FSM states: IDLE, WR_DATA, COMMIT, RESP_LOAD, RESP_SEND, RESP_WAIT.
- IDLE: on rx_valid, latch cmd.
  - Write: go to WR_DATA, counter=0.
  - Read of a legal address: load the response shift register with reg[addr], count=DATA_BYTES, go to RESP_LOAD.
  - Read of an illegal address: response is one byte 0xEE.
- WR_DATA: each rx_valid shifts the byte in, MSB byte first. After DATA_BYTES bytes, go to COMMIT.
- COMMIT, one cycle:
  - Legal address: reg[addr] <= assembled word, wr_strobe=1, wr_addr=addr, response one byte 0xA5.
  - Illegal address: no write, no strobe, response 0xEE.
  - Then go to RESP_LOAD.
- Write latency: the register updates on the edge ending COMMIT, one cycle after the last data byte's rx_valid.
- RESP_LOAD: when tx_busy=0, drive tx_data with the next byte and pulse tx_start for one cycle, then go to RESP_SEND.
- RESP_SEND: ignore tx_busy for exactly one cycle, then go to RESP_WAIT.
- RESP_WAIT: when tx_busy=0, decrement the count. If bytes remain, go to RESP_LOAD; else go to IDLE.
- Read data is sent MSB byte first. The word is snapshotted in IDLE and is unaffected by later writes.
- rx_valid in RESP_LOAD/RESP_SEND/RESP_WAIT: byte discarded, drop_err <= 1. drop_err clears only on reset.
- rx_valid in COMMIT: byte discarded and drop_err set, since a response always follows COMMIT.
- Back-to-back commands: a new command is accepted in IDLE on the cycle after the final RESP_WAIT exit.
- DATA_BYTES=1: WR_DATA takes exactly one byte.
- regs_q is a direct register output with no combinational path from rx.

Optional Feature:
Macro UART_REG_BRIDGE_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYC, default 1_000_000. A counter runs in WR_DATA, reloads on every rx_valid, and on expiry returns the FSM to IDLE with no write and no response.
- Undefined: WR_DATA waits indefinitely, and no counter logic exists.

Decomposition:
- Shared package uart_reg_pkg holds:
  - constants RSP_ACK=8'hA5, RSP_ERR=8'hEE, CMD_WR_BIT=7
  - the FSM state enum typedef
  - function addr_legal(cmd, ADDR_W, NUM_REGS)
- One sub-module: uart_reg_bank, holding NUM_REGS x DATA_W storage, the write port, the flattened output and the read mux. The bridge FSM stays in uart_reg_bridge.

Test Plan:
- Write then read, ADDR_W=4, DATA_BYTES=2: rx 0x83,0x12,0x34 -> wr_strobe pulse with wr_addr=3, regs_q[3]=0x1234, tx 0xA5. Then rx 0x03 -> tx 0x12 then 0x34.
- Illegal address, NUM_REGS=12: rx 0x8D,0xFF,0xFF -> no write, tx 0xEE. rx 0x0E -> tx 0xEE. rx 0x13 (nonzero high bits) -> tx 0xEE.
- Drop during response: rx 0x00, then inject rx 0x55 while tx_busy=1 -> drop_err=1, read response unchanged, and the next command is parsed normally.
- Reset mid-write: rx 0x81,0xAA, then nRst=0 for one cycle -> regs all 0, no tx. Then rx 0x81,0x01,0x02 -> reg1=0x0102.
- Slow transmitter: hold tx_busy=1 for 20 cycles per byte -> exactly one tx_start per byte, tx_data stable until the next tx_start.
- With UART_REG_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=50: rx 0x82,0x11, idle 60 cycles, then rx 0x02 -> reg2 unchanged (0), tx 0x00,0x00.
